// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Word-addressed data memory for the CPU, with a second port for a host/debug
// initiator.
//
// CPU port  : combinational read (dmem_out), full-word write at the clock edge.
// Host port : valid/ready request. Writes land at the edge. Reads return one
//             cycle later on dmem_out_p1, qualified by a single-cycle
//             p1_rvalid pulse.
//
// Both ports take the word index from addr[$clog2(DEPTH)+1:2]. The two low
// bits and all bits above the index are ignored, so misaligned addresses hit
// the containing word and addresses alias modulo 4*DEPTH.
//
// A CPU write always wins. A host write that collides with any CPU write is
// stalled (p1_ready=0), and the host must hold the request. Host reads are
// never stalled. Reads on either port that coincide with a write to the same
// word return the old contents.
//
// Compile-time option:
//   DMEM_CLEAR_ON_RESET_EN - after reset, a clear sequencer zeroes every word
//                            (one per cycle, DEPTH cycles). During the clear,
//                            busy=1, dmem_out=0 and neither port can access
//                            the array. Without the macro, busy is tied to 0,
//                            the array keeps its contents across reset, and
//                            reset only clears the host read-return registers.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   dmem_addr      CPU byte address
//   dmem_we        CPU write enable
//   dmem_wd        CPU write data
//   dmem_out       CPU read data (combinational)
//   dmem_addr_p1   host byte address
//   dmem_wd_p1     host write data
//   p1_valid       host request valid
//   p1_we          host request is a write
//   p1_ready       host request accepted when p1_valid && p1_ready
//   dmem_out_p1    host read data (registered; holds between reads)
//   p1_rvalid      host read data valid (one-cycle pulse)
//   busy           clear sequence in progress
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_we,
    input  logic [DATA_WIDTH-1:0] dmem_wd,
    output logic [DATA_WIDTH-1:0] dmem_out,
    input  logic [DATA_WIDTH-1:0] dmem_addr_p1,
    input  logic [DATA_WIDTH-1:0] dmem_wd_p1,
    input  logic                  p1_valid,
    input  logic                  p1_we,
    output logic                  p1_ready,
    output logic [DATA_WIDTH-1:0] dmem_out_p1,
    output logic                  p1_rvalid,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] cpu_idx;
    logic [IDX_W-1:0] host_idx;
    logic             in_idle;   // array available to both ports
    logic             cpu_wr;
    logic             host_acc;
    logic             host_wr;
    logic             host_rd;

    // Only the word-index slice of each address is meaningful. The full
    // buses are folded here so the ignored bits are visibly accounted for.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr, dmem_addr_p1};

    assign cpu_idx  = dmem_addr[IDX_W+1:2];
    assign host_idx = dmem_addr_p1[IDX_W+1:2];

`ifdef DMEM_CLEAR_ON_RESET_EN
    // -------------------------------------------------------------------------
    // Post-reset clear sequencer
    // -------------------------------------------------------------------------
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] clr_ptr;
    logic             clr_last;

    assign clr_last = (clr_ptr == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            // DEPTH is a power of two, so the pointer wraps back to 0 on the
            // edge that leaves CLEAR.
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_idle   = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                in_idle = 1'b1;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign busy = !in_idle;
`else
    assign in_idle = 1'b1;
    assign busy    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Port arbitration
    // -------------------------------------------------------------------------
    // The CPU has priority. A host write stalls whenever the CPU writes, even
    // to a different word, so the array only needs one write port.
    assign p1_ready = in_idle && !(p1_we && dmem_we);
    assign host_acc = p1_valid && p1_ready;
    assign cpu_wr   = in_idle && dmem_we;
    assign host_wr  = host_acc && p1_we;
    assign host_rd  = host_acc && !p1_we;

    // CPU read: combinational. It shows the old word during a same-cycle
    // write, and forced zero while the clear runs.
    assign dmem_out = in_idle ? mem[cpu_idx] : '0;

    // -------------------------------------------------------------------------
    // Array write port
    // -------------------------------------------------------------------------
    // Nothing is written on a reset edge. Words cleared before a mid-clear
    // reset therefore stay zero until the restarted sequence reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            if (!in_idle) begin
                mem[clr_ptr] <= '0;
            end
`endif
            if (cpu_wr) begin
                mem[cpu_idx] <= dmem_wd;
            end else if (host_wr) begin
                mem[host_idx] <= dmem_wd_p1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Host read return
    // -------------------------------------------------------------------------
    // The data is captured from the pre-edge array contents. A read accepted
    // during a reset edge is dropped because the reset branch wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p1_rvalid   <= 1'b0;
            dmem_out_p1 <= '0;
        end else begin
            p1_rvalid <= host_rd;
            if (host_rd) begin
                dmem_out_p1 <= mem[host_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Scoreboard bench for dmem_responder with DEPTH=16.
//
// The driver task applies one cycle of stimulus and checks the combinational
// outputs (dmem_out, p1_ready, busy) against a word-array model. Each host
// read it issues pushes the expected return value into a queue. A separate
// monitor checks p1_rvalid and dmem_out_p1 on every falling edge.
//
// The bench works with and without DMEM_CLEAR_ON_RESET_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dmem_addr;
    logic          dmem_we;
    logic [DW-1:0] dmem_wd;
    logic [DW-1:0] dmem_out;
    logic [DW-1:0] dmem_addr_p1;
    logic [DW-1:0] dmem_wd_p1;
    logic          p1_valid;
    logic          p1_we;
    logic          p1_ready;
    logic [DW-1:0] dmem_out_p1;
    logic          p1_rvalid;
    logic          busy;

    dmem_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_addr    (dmem_addr),
        .dmem_we      (dmem_we),
        .dmem_wd      (dmem_wd),
        .dmem_out     (dmem_out),
        .dmem_addr_p1 (dmem_addr_p1),
        .dmem_wd_p1   (dmem_wd_p1),
        .p1_valid     (p1_valid),
        .p1_we        (p1_we),
        .p1_ready     (p1_ready),
        .dmem_out_p1  (dmem_out_p1),
        .p1_rvalid    (p1_rvalid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            known;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] model [DEPTH];
    bit            known [DEPTH];
    int            busy_left;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_last;
    bit            last_known = 1'b0;
    logic          rst_q = 1'b1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [DW-1:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // One clock cycle: drive the inputs, check the combinational outputs,
    // then advance the model across the edge.
    task automatic step(input bit r, input bit we, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                        input bit v, input bit pwe, input logic [DW-1:0] pa, input logic [DW-1:0] pwd);
        bit exp_rdy;
        bit acc;
        int ci;
        int hi;
        rst = r; dmem_we = we; dmem_addr = a; dmem_wd = wd;
        p1_valid = v; p1_we = pwe; dmem_addr_p1 = pa; dmem_wd_p1 = pwd;
        #1;
        ci      = widx(a);
        hi      = widx(pa);
        exp_rdy = (busy_left == 0) && !(pwe && we);
        if (cyc > 0) begin
            chk("busy", DW'(busy), DW'(busy_left != 0));
            chk("p1_ready", DW'(p1_ready), DW'(exp_rdy));
            if (busy_left != 0) chk("dmem_out_clear", dmem_out, '0);
            else if (known[ci]) chk("dmem_out", dmem_out, model[ci]);
        end
        acc = v && exp_rdy;
        @(posedge clk);
        cyc++;
        if (!r) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                model[i] = '0;
                known[i] = 1'b1;
            end
`endif
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (acc && !pwe) sb.push_back('{model[hi], known[hi], cyc});
            if (we) begin
                model[ci] = wd;
                known[ci] = 1'b1;
            end else if (acc && pwe) begin
                model[hi] = pwd;
                known[hi] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_clear();
        for (int i = 0; i < 3 * DEPTH && busy_left != 0; i++) idle();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, DW'(i * 4), '0, 1'b1, 1'b0, DW'(i * 4 + DEPTH * 4), '0);
    endtask

    // Host read-return monitor
    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (!rst_q) begin
                chk("rvalid_rst", DW'(p1_rvalid), '0);
                chk("out_p1_rst", dmem_out_p1, '0);
                exp_last   = '0;
                last_known = 1'b1;
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("rvalid", DW'(p1_rvalid), DW'(1));
                if (mon_e.known) chk("out_p1", dmem_out_p1, mon_e.data);
                exp_last   = mon_e.data;
                last_known = mon_e.known;
            end else begin
                chk("rvalid_idle", DW'(p1_rvalid), '0);
                if (last_known) chk("out_p1_hold", dmem_out_p1, exp_last);
            end
        end
    end

    initial begin
        bit r;
        bit we;
        bit v;
        bit pwe;
`ifdef DMEM_CLEAR_ON_RESET_EN
        busy_left = DEPTH;
`else
        busy_left = 0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        rst = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wd = '0;
        p1_valid = 1'b0; p1_we = 1'b0; dmem_addr_p1 = '0; dmem_wd_p1 = '0;

        // Reset, with a host read offered during reset (must not return).
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h4, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h8, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_clear();
`ifndef DMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, DW'(i * 4), '0, 1'b0, 1'b0, '0, '0);
`endif
        read_all();

        // CPU write, read back through aliased and misaligned addresses.
        step(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'h40, '0, 1'b1, 1'b0, 32'h40, '0);
        step(1'b1, 1'b0, 32'h40 + DEPTH * 4, '0, 1'b1, 1'b0, 32'h43, '0);
        step(1'b1, 1'b0, 32'h43, '0, 1'b0, 1'b0, '0, '0);

        // Write collision: the host stalls and holds, then lands.
        step(1'b1, 1'b1, 32'h8, 32'h11111111, 1'b1, 1'b1, 32'h8, 32'h22222222);
        step(1'b1, 1'b0, 32'h8, '0, 1'b1, 1'b1, 32'h8, 32'h22222222);
        step(1'b1, 1'b0, 32'h8, '0, 1'b0, 1'b0, '0, '0);

        // Host read alongside a CPU write to the same word returns old data.
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 32'h8, 32'hAAAA0000);
        step(1'b1, 1'b1, 32'h8, 32'h00005555, 1'b1, 1'b0, 32'h8, '0);
        idle();
        idle();

        // Back-to-back host reads.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, $urandom, '0);
        idle();

        // Preload word 3, then pulse reset.
        step(1'b1, 1'b1, 32'hC, 32'hCAFEF00D, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'hC, '0, 1'b0, 1'b0, '0, '0);
        wait_clear();
        step(1'b1, 1'b0, 32'hC, '0, 1'b1, 1'b0, 32'hC, '0);

        // Reset in the middle of a clear.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) idle();
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_clear();
        read_all();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            we  = r && ($urandom_range(0, 2) == 0);
            v   = ($urandom_range(0, 1) == 1);
            pwe = r && ($urandom_range(0, 1) == 1);
            step(r, we, $urandom, $urandom, v, pwe, $urandom, $urandom);
        end
        idle();
        wait_clear();
        idle();
        idle();
        chk("sb_drained", DW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
